// File: rtl/ascii_digit_packer.sv
`default_nettype none
// ============================================================================
//  Module   : ascii_digit_packer
//  Purpose  : Collects decimal ASCII digit characters from a byte stream and
//             emits one right-aligned, '0'-padded word of NDIG characters per
//             number (MS character in the top byte). A number ends after NDIG
//             digits or on the TERM character. A non-digit, non-TERM byte
//             raises a one-cycle err pulse and drops input until the next TERM.
//  Ports    : clk        system clock, rising edge
//             rst_n      asynchronous active-low reset
//             in_byte    incoming character
//             in_valid   in_byte valid
//             in_ready   packer can accept in_byte (decoded from state only)
//             out_ascii  packed ASCII digits (the buffer register)
//             out_valid  out_ascii holds a complete word
//             out_ready  downstream accepts the word
//             err        one-cycle pulse after an illegal character
//  Revision : 1.0  initial release
// ============================================================================
module ascii_digit_packer #(
  parameter int         NDIG = 4,
  parameter logic [7:0] TERM = 8'h0D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [8*NDIG-1:0] out_ascii,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err
);

  localparam int              W          = 8 * NDIG;
  localparam int              CW         = $clog2(NDIG) + 1;
  localparam logic [W-1:0]    c_pad      = {NDIG{8'h30}};
  localparam logic [CW-1:0]   c_cnt_last = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_DISCARD = 2'd1,
    S_OUT     = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [W-1:0]    buf_q,   buf_d;
  logic            err_q,   err_d;

  logic            w_accept;
  logic            w_is_digit;
  logic            w_is_term;
  logic [W-1:0]    w_shifted;

  assign in_ready   = (state_q != S_OUT);
  assign out_valid  = (state_q == S_OUT);
  assign out_ascii  = buf_q;
  assign err        = err_q;

  assign w_accept   = in_valid && in_ready;
  assign w_is_digit = (in_byte >= 8'h30) && (in_byte <= 8'h39);
  assign w_is_term  = (in_byte == TERM);

  // Shift-left insertion keeps the number right-aligned; the untouched upper
  // bytes keep their '0' padding from the last buffer clear.
  generate
    if (NDIG > 1) begin : g_shift_multi
      assign w_shifted = {buf_q[W-9:0], in_byte};
    end else begin : g_shift_single
      assign w_shifted = in_byte;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    err_d   = 1'b0;
    case (state_q)
      S_COLLECT: begin
        if (w_accept) begin
          if (w_is_digit) begin
            buf_d = w_shifted;
            if (cnt_q == c_cnt_last) begin
              state_d = S_OUT;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else if (w_is_term) begin
            // A TERM with nothing collected (e.g. CR after a full word) is
            // simply swallowed.
            if (cnt_q != '0) begin
              state_d = S_OUT;
            end
          end else begin
            err_d   = 1'b1;
            buf_d   = c_pad;
            cnt_d   = '0;
            state_d = S_DISCARD;
          end
        end
      end
      S_DISCARD: begin
        // Drop everything until TERM; repeated junk does not re-pulse err.
        if (w_accept && w_is_term) begin
          state_d = S_COLLECT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_COLLECT;
          cnt_d   = '0;
          buf_d   = c_pad;
        end
      end
      default: begin
        state_d = S_COLLECT;
        cnt_d   = '0;
        buf_d   = c_pad;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_COLLECT;
      cnt_q   <= '0;
      buf_q   <= c_pad;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ascii_digit_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ascii_digit_packer
//  Purpose  : Directed self-checking bench for ascii_digit_packer (NDIG=4,
//             TERM=CR). Inputs change on the falling edge; outputs are
//             sampled 1 ns after the rising edge or on the falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ascii_digit_packer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_ascii;
  logic        out_valid;
  logic        out_ready;
  logic        err;

  int errors = 0;
  int checks = 0;

  ascii_digit_packer #(.NDIG(4), .TERM(8'h0D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_ascii (out_ascii),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one byte and hold it until accepted (bounded wait on in_ready).
  task automatic send(input logic [7:0] b);
    int n;
    @(negedge clk);
    in_byte  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err); end
    checks++; if (out_ascii !== 32'h30303030) begin errors++; $display("FAIL rst_ascii: got %h expected 30303030", out_ascii); end
  endtask

  task automatic test_lone_term();
    logic [7:0] seq [3];
    seq = '{8'h0D, 8'h0D, 8'h0D};
    for (int i = 0; i < 3; i++) begin
      send(seq[i]);
      checks++; if (out_valid !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL lone_term_%0d: got valid=%b err=%b ready=%b expected 0 0 1", i, out_valid, err, in_ready);
      end
    end
  endtask

  task automatic test_full_word();
    out_ready = 1'b1;
    send(8'h31); send(8'h39); send(8'h38); send(8'h37);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b expected 1", out_valid); end
    checks++; if (out_ascii !== 32'h31393837) begin errors++; $display("FAIL full_ascii: got %h expected 31393837", out_ascii); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL full_one_cycle: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
    end
    checks++; if (out_ascii !== 32'h30303030) begin errors++; $display("FAIL full_cleared: got %h expected 30303030", out_ascii); end
  endtask

  task automatic test_short_term();
    out_ready = 1'b1;
    send(8'h34); send(8'h32); send(8'h0D);
    checks++; if (out_valid !== 1'b1 || out_ascii !== 32'h30303432) begin
      errors++; $display("FAIL short_word: got valid=%b ascii=%h expected 1 30303432", out_valid, out_ascii);
    end
    @(posedge clk); #1;
    send(8'h0D);
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b0 || err !== 1'b0) begin
        errors++; $display("FAIL short_trailing_cr_%0d: got valid=%b err=%b expected 0 0", i, out_valid, err);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    send(8'h31);
    send(8'h61);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err_pulse: got %b expected 1", err); end
    checks++; if (out_ascii !== 32'h30303030) begin errors++; $display("FAIL illegal_buf_clear: got %h expected 30303030", out_ascii); end
    send(8'h35);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL illegal_err_width: got %b expected 0", err); end
    send(8'h0D);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL illegal_cr_dropped: got %b expected 0", out_valid); end
    send(8'h39); send(8'h39); send(8'h39); send(8'h39);
    checks++; if (out_valid !== 1'b1 || out_ascii !== 32'h39393939) begin
      errors++; $display("FAIL illegal_resync: got valid=%b ascii=%h expected 1 39393939", out_valid, out_ascii);
    end
    @(posedge clk); #1;
    // Consecutive junk must pulse err only once.
    send(8'h61);
    send(8'h62);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL discard_no_repulse: got %b expected 0", err); end
    send(8'h0D);
    send(8'h38); send(8'h0D);
    checks++; if (out_valid !== 1'b1 || out_ascii !== 32'h30303038) begin
      errors++; $display("FAIL discard_recover: got valid=%b ascii=%h expected 1 30303038", out_valid, out_ascii);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(8'h36); send(8'h35); send(8'h34); send(8'h30);
    in_byte  = 8'h31;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_ascii !== 32'h36353430 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold_%0d: got valid=%b ascii=%h ready=%b expected 1 36353430 0", i, out_valid, out_ascii, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ascii !== 32'h30303030) begin
      errors++; $display("FAIL bp_release: got valid=%b ready=%b ascii=%h expected 0 1 30303030", out_valid, in_ready, out_ascii);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_ascii !== 32'h30303031) begin errors++; $display("FAIL bp_next_byte: got %h expected 30303031", out_ascii); end
    send(8'h0D);
    checks++; if (out_valid !== 1'b1 || out_ascii !== 32'h30303031) begin
      errors++; $display("FAIL bp_next_word: got valid=%b ascii=%h expected 1 30303031", out_valid, out_ascii);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send(8'h33); send(8'h33);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_ascii !== 32'h30303030 || err !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_state: got valid=%b ascii=%h err=%b ready=%b expected 0 30303030 0 1", out_valid, out_ascii, err, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h37); send(8'h0D);
    checks++; if (out_valid !== 1'b1 || out_ascii !== 32'h30303037) begin
      errors++; $display("FAIL midrst_word: got valid=%b ascii=%h expected 1 30303037", out_valid, out_ascii);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_lone_term();
    test_full_word();
    test_short_term();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
